// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA raster scanout: timing counters, frame-buffer addressing, registered syncs
module vga_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int PIXEL_DEPTH = 8,
    parameter int SYNC_POL    = 0,
    localparam int H_TOTAL          = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL          = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int PIXEL_ADDR_WIDTH = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic                        pxclk,
    input  logic                        rst_n,
    input  logic                        enable,
    output logic [PIXEL_ADDR_WIDTH-1:0] px_addr,
    input  logic [PIXEL_DEPTH-1:0]      px_data,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        de,
    output logic [PIXEL_DEPTH-1:0]      pixel,
    output logic                        frame_start
);

    localparam int H_CNT_W = $clog2(H_TOTAL);
    localparam int V_CNT_W = $clog2(V_TOTAL);

    localparam logic [H_CNT_W-1:0] H_ACT_C  = H_CNT_W'(H_ACTIVE);
    localparam logic [H_CNT_W-1:0] H_LAST_C = H_CNT_W'(H_TOTAL - 1);
    localparam logic [H_CNT_W-1:0] HS_BEG_C = H_CNT_W'(H_ACTIVE + H_FP);
    localparam logic [H_CNT_W-1:0] HS_END_C = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_CNT_W-1:0] V_ACT_C  = V_CNT_W'(V_ACTIVE);
    localparam logic [V_CNT_W-1:0] V_LAST_C = V_CNT_W'(V_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] VS_BEG_C = V_CNT_W'(V_ACTIVE + V_FP);
    localparam logic [V_CNT_W-1:0] VS_END_C = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic               SYNC_ACT = (SYNC_POL != 0);

    logic [H_CNT_W-1:0]          hcnt;
    logic [V_CNT_W-1:0]          vcnt;
    logic [H_CNT_W-1:0]          hcnt_nxt;
    logic [V_CNT_W-1:0]          vcnt_nxt;
    logic [PIXEL_ADDR_WIDTH-1:0] addr_nxt;
    logic                        visible;
    logic                        hs_zone;
    logic                        vs_zone;
    logic                        origin;

    always_comb begin
        hcnt_nxt = hcnt + H_CNT_W'(1);
        vcnt_nxt = vcnt;
        if (hcnt == H_LAST_C) begin
            hcnt_nxt = '0;
            vcnt_nxt = (vcnt == V_LAST_C) ? '0 : vcnt + V_CNT_W'(1);
        end
        visible = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
        hs_zone = (hcnt >= HS_BEG_C) && (hcnt <= HS_END_C);
        vs_zone = (vcnt >= VS_BEG_C) && (vcnt <= VS_END_C);
        origin  = (hcnt == '0) && (vcnt == '0);
        // Address steps only past visible pixels, so after a line's last pixel it
        // already holds the next line's first index; vertical blanking parks it at 0.
        if (vcnt_nxt >= V_ACT_C) begin
            addr_nxt = '0;
        end else if (visible) begin
            addr_nxt = px_addr + PIXEL_ADDR_WIDTH'(1);
        end else begin
            addr_nxt = px_addr;
        end
    end

    always_ff @(posedge pxclk) begin
        if (!rst_n || !enable) begin
            hcnt        <= '0;
            vcnt        <= '0;
            px_addr     <= '0;
            de          <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~SYNC_ACT;
            vsync       <= ~SYNC_ACT;
        end else begin
            hcnt        <= hcnt_nxt;
            vcnt        <= vcnt_nxt;
            px_addr     <= addr_nxt;
            // Stage 1 lines up with px_data returned for the address issued this cycle.
            de          <= visible;
            frame_start <= origin;
            hsync       <= hs_zone ? SYNC_ACT : ~SYNC_ACT;
            vsync       <= vs_zone ? SYNC_ACT : ~SYNC_ACT;
        end
    end

    assign pixel = de ? px_data : '0;

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - scoreboard bench for vga_scanout on a reduced raster
module tb_vga_scanout;

    localparam int HA = 16, HF = 2, HS = 3, HB = 4;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int AW = 7;

    typedef struct {
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [7:0] pix;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [AW-1:0] px_addr;
    logic [7:0]    px_data;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [7:0]    pixel;
    logic          frame_start;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   mh = 0;
    int   mv = 0;
    int   last_fs = -1;
    int   fs_seen = 0;
    int   de_seen = 0;
    bit   check_gap = 0;
    bit   const_mode = 0;

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIXEL_DEPTH(8), .SYNC_POL(0)
    ) dut (
        .pxclk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .px_addr(px_addr),
        .px_data(px_data),
        .hsync(hsync),
        .vsync(vsync),
        .de(de),
        .pixel(pixel),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] fb(input logic [AW-1:0] a);
        logic [7:0] w;
        w = {1'b0, a};
        return const_mode ? 8'hAA : (w ^ 8'h5A);
    endfunction

    function automatic int exp_addr(input int h, input int v);
        if (v >= VA) return 0;
        if (h < HA) return v * HA + h;
        return v * HA + HA;
    endfunction

    // One pixel clock: push the stage-1 expectation for this edge, advance the
    // model raster, answer the frame-buffer read, then check on the falling edge.
    task automatic step(input logic en, input logic rn);
        exp_t          e;
        logic [AW-1:0] a_prev;
        int            ea;
        a_prev = px_addr;
        enable = en;
        rst_n  = rn;
        if (!rn || !en) begin
            e = '{de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, pix: 8'h00};
            mh = 0;
            mv = 0;
            ea = 0;
        end else begin
            e.de  = (mh < HA) && (mv < VA);
            e.hs  = !((mh >= HA + HF) && (mh <= HA + HF + HS - 1));
            e.vs  = !((mv >= VA + VF) && (mv <= VA + VF + VS - 1));
            e.fs  = (mh == 0) && (mv == 0);
            e.pix = e.de ? fb(AW'(mv * HA + mh)) : 8'h00;
            mh = mh + 1;
            if (mh == HT) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end
            ea = exp_addr(mh, mv);
        end
        q.push_back(e);
        @(posedge clk);
        #1 px_data = fb(a_prev);
        @(negedge clk);
        cyc = cyc + 1;
        e = q.pop_front();
        total = total + 5;
        if (px_addr !== AW'(ea)) begin
            bad = bad + 1;
            if (bad < 30) $display("FAIL px_addr cyc=%0d got=%0d want=%0d", cyc, px_addr, ea);
        end
        if (de !== e.de) begin
            bad = bad + 1;
            if (bad < 30) $display("FAIL de cyc=%0d got=%b want=%b", cyc, de, e.de);
        end
        if ({hsync, vsync} !== {e.hs, e.vs}) begin
            bad = bad + 1;
            if (bad < 30) $display("FAIL syncs cyc=%0d got=%b%b want=%b%b", cyc, hsync, vsync, e.hs, e.vs);
        end
        if (frame_start !== e.fs) begin
            bad = bad + 1;
            if (bad < 30) $display("FAIL frame_start cyc=%0d got=%b want=%b", cyc, frame_start, e.fs);
        end
        if (pixel !== e.pix) begin
            bad = bad + 1;
            if (bad < 30) $display("FAIL pixel cyc=%0d got=%h want=%h", cyc, pixel, e.pix);
        end
        if (de === 1'b1) de_seen = de_seen + 1;
        if (frame_start === 1'b1) begin
            fs_seen = fs_seen + 1;
            if (check_gap && last_fs >= 0) begin
                total = total + 1;
                if (cyc - last_fs != HT * VT) begin
                    bad = bad + 1;
                    $display("FAIL fs_period got=%0d want=%0d", cyc - last_fs, HT * VT);
                end
            end
            last_fs = cyc;
        end
    endtask

    task automatic run_to(input int h, input int v);
        int n;
        n = 0;
        while (!(mh == h && mv == v) && n < 2 * HT * VT) begin
            step(1'b1, 1'b1);
            n = n + 1;
        end
        total = total + 1;
        if (n >= 2 * HT * VT) begin
            bad = bad + 1;
            $display("FAIL run_to (%0d,%0d) not reached", h, v);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1);
    endtask

    task automatic test_first_line;
        de_seen = 0;
        fs_seen = 0;
        for (int i = 0; i < HT; i++) step(1'b1, 1'b1);
        total = total + 2;
        if (de_seen != HA) begin
            bad = bad + 1;
            $display("FAIL line_de_count got=%0d want=%0d", de_seen, HA);
        end
        if (fs_seen != 1) begin
            bad = bad + 1;
            $display("FAIL line_fs_count got=%0d want=1", fs_seen);
        end
    endtask

    task automatic test_frame;
        check_gap = 1;
        fs_seen = 0;
        de_seen = 0;
        for (int i = 0; i < 2 * HT * VT; i++) step(1'b1, 1'b1);
        check_gap = 0;
        total = total + 2;
        if (fs_seen != 2) begin
            bad = bad + 1;
            $display("FAIL frame_fs_count got=%0d want=2", fs_seen);
        end
        if (de_seen != 2 * HA * VA) begin
            bad = bad + 1;
            $display("FAIL frame_de_count got=%0d want=%0d", de_seen, 2 * HA * VA);
        end
    endtask

    task automatic test_enable_drop;
        run_to(10, 3);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        for (int i = 0; i < HT * VT + HT; i++) step(1'b1, 1'b1);
    endtask

    task automatic test_reset_mid;
        run_to(12, 4);
        step(1'b1, 1'b0);
        for (int i = 0; i < 2 * HT; i++) step(1'b1, 1'b1);
    endtask

    task automatic test_const_data;
        const_mode = 1;
        for (int i = 0; i < HT * VT + 3; i++) step(1'b1, 1'b1);
        const_mode = 0;
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1);
            for (int i = 0; i < HT + k * 7; i++) step(1'b1, 1'b1);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        px_data = 8'h00;
        @(negedge clk);
        test_reset();
        test_first_line();
        test_frame();
        test_enable_drop();
        test_reset_mid();
        test_const_data();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
